// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline arbiters.
//   - pipe_state_e : packet arbitration state (IDLE = free to arbitrate,
//                    LOCK = a multi-beat packet owns the output stage)
//   - clog2        : ceiling log2, used to validate index-width parameters
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [0:0] {
    PIPE_IDLE = 1'b0,
    PIPE_LOCK = 1'b1
  } pipe_state_e;

  // Ceiling log2 with clog2(1) = 0; written as a loop so it is usable in
  // constant expressions on every tool.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Searches eligible_i starting
//   at rr_ptr_i and wrapping modulo NUM; the first set bit wins.
//
//   Ports
//     eligible_i  [NUM]  candidate requesters
//     rr_ptr_i    [IDW]  highest-priority index this cycle (must be < NUM)
//     grant_o     [NUM]  one-hot winner, zero when nothing is eligible
//     idx_o       [IDW]  binary index of the winner (0 when none)
//     any_o              at least one requester is eligible
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM = 4,
  parameter int IDW = 2
) (
  input  logic [NUM-1:0] eligible_i,
  input  logic [IDW-1:0] rr_ptr_i,
  output logic [NUM-1:0] grant_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      // Rotated index; rr_ptr_i < NUM so a single subtract is enough, and
      // indices >= NUM can never be produced even for non-power-of-2 NUM.
      j = int'(rr_ptr_i) + k;
      if (j >= NUM) begin
        j = j - NUM;
      end
      if (!any_o && eligible_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arb.sv
// ---------------------------------------------------------------------------
// pipe_rr_arb
//   Packet-aware round-robin arbiter feeding one registered pipeline stage.
//   A requester that wins with a non-last beat keeps the grant until its
//   last beat is accepted. The output register loads whenever it is empty
//   or being drained in the same cycle (bubble-free).
//
//   Ports
//     clock       system clock
//     rst         synchronous, active-high reset
//     cfg_mask    [NUM]        per-requester enable (ignored while locked)
//     req_vld     [NUM]        requester i presents a beat
//     req_data    [NUM*DSIZE]  beat data, slice i = [i*DSIZE +: DSIZE]
//     req_last    [NUM]        beat is the last of its packet
//     req_reload  [NUM]        combinational accept strobe, one-hot or zero
//     out_vld                  output register holds a beat (downstream wr_en)
//     out_data    [DSIZE]      registered beat
//     out_id      [IDW]        source index of out_data
//     out_last                 registered last flag
//     low_empty               downstream takes out_data this cycle
//     busy                     a packet currently holds the grant
// ---------------------------------------------------------------------------
module pipe_rr_arb
  import pipe_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int IDW   = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM-1:0]       cfg_mask,
  input  logic [NUM-1:0]       req_vld,
  input  logic [NUM*DSIZE-1:0] req_data,
  input  logic [NUM-1:0]       req_last,
  output logic [NUM-1:0]       req_reload,
  output logic                 out_vld,
  output logic [DSIZE-1:0]     out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 out_last,
  input  logic                 low_empty,
  output logic                 busy
);

  generate
    if (IDW != clog2(NUM) || NUM < 2 || NUM > 16) begin : g_bad_param
      $error("pipe_rr_arb: NUM must be 2..16 and IDW must equal clog2(NUM)");
    end
  endgenerate

  pipe_state_e      state_q,    state_d;
  logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDW-1:0]   lock_id_q,  lock_id_d;
  logic             out_vld_q,  out_vld_d;
  logic [DSIZE-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]   out_id_q,   out_id_d;
  logic             out_last_q, out_last_d;

  logic [NUM-1:0]   eligible;
  logic [NUM-1:0]   pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

  logic             load_ok;
  logic             acc;
  logic [IDW-1:0]   acc_idx;
  logic [DSIZE-1:0] acc_data;
  logic             acc_last;

  assign eligible = req_vld & cfg_mask;

  // The output stage can take a new beat when empty, or when its current
  // beat leaves this same cycle.
  assign load_ok = !out_vld_q || low_empty;

  rr_pick #(
    .NUM (NUM),
    .IDW (IDW)
  ) u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (pick_grant),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  // Accept decision. While locked only the owner is considered and its mask
  // bit is ignored so a packet in flight is never cut short.
  always_comb begin
    acc        = 1'b0;
    acc_idx    = '0;
    req_reload = '0;
    if (state_q == PIPE_IDLE) begin
      acc     = pick_any && load_ok;
      acc_idx = pick_idx;
      if (acc && !rst) begin
        req_reload = pick_grant;
      end
    end else begin
      acc     = req_vld[lock_id_q] && load_ok;
      acc_idx = lock_id_q;
      if (acc && !rst) begin
        req_reload[lock_id_q] = 1'b1;
      end
    end
  end

  assign acc_data = req_data[int'(acc_idx)*DSIZE +: DSIZE];
  assign acc_last = req_last[acc_idx];

  // Next-state for FSM, round-robin pointer and output register.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_id_d  = lock_id_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    out_last_d = out_last_q;

    if (acc) begin
      out_vld_d  = 1'b1;
      out_data_d = acc_data;
      out_id_d   = acc_idx;
      out_last_d = acc_last;
      if (acc_last) begin
        // Packet complete: the requester after the winner gets top priority.
        state_d  = PIPE_IDLE;
        rr_ptr_d = next_idx(acc_idx);
      end else if (state_q == PIPE_IDLE) begin
        state_d   = PIPE_LOCK;
        lock_id_d = acc_idx;
      end
    end else if (out_vld_q && low_empty) begin
      // Drained with nothing to replace it: present an empty, zeroed stage.
      out_vld_d  = 1'b0;
      out_data_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= PIPE_IDLE;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_id   = out_id_q;
  assign out_last = out_last_q;
  assign busy     = (state_q == PIPE_LOCK);

  // Increment modulo NUM so the pointer never leaves 0..NUM-1.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (idx == IDW'(NUM - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endmodule

// File: tb/tb_pipe_rr_arb.sv
module tb_pipe_rr_arb;

  localparam int NUM   = 4;
  localparam int DSIZE = 8;
  localparam int IDW   = 2;

  logic                 clock;
  logic                 rst;
  logic [NUM-1:0]       cfg_mask;
  logic [NUM-1:0]       req_vld;
  logic [NUM*DSIZE-1:0] req_data;
  logic [NUM-1:0]       req_last;
  logic [NUM-1:0]       req_reload;
  logic                 out_vld;
  logic [DSIZE-1:0]     out_data;
  logic [IDW-1:0]       out_id;
  logic                 out_last;
  logic                 low_empty;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  // Expected beats as {data, id, last}.
  logic [DSIZE+IDW:0] sb_q[$];

  pipe_rr_arb #(.NUM(NUM), .DSIZE(DSIZE), .IDW(IDW)) dut (
    .clock      (clock),
    .rst        (rst),
    .cfg_mask   (cfg_mask),
    .req_vld    (req_vld),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_reload (req_reload),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .low_empty  (low_empty),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input int i, input logic [DSIZE-1:0] v);
    req_data[i*DSIZE +: DSIZE] = v;
  endtask

  // One cycle: inputs already driven. At the negedge check the accept strobe
  // and busy (and optionally the output register), push the expected beat of
  // any accept, then move to just after the next posedge.
  task automatic cyc(input logic [NUM-1:0] rl, input logic bz,
                     input bit do_out = 0, input logic ovld = 0,
                     input logic [DSIZE-1:0] odata = 0);
    int id;
    @(negedge clock);
    chk("req_reload", 32'(req_reload), 32'(rl));
    chk("busy", 32'(busy), 32'(bz));
    if (do_out) begin
      chk("out_vld", 32'(out_vld), 32'(ovld));
      chk("out_data", 32'(out_data), 32'(odata));
    end
    if (rl != '0) begin
      id = 0;
      for (int k = 0; k < NUM; k++) if (rl[k]) id = k;
      sb_q.push_back({req_data[id*DSIZE +: DSIZE], IDW'(id), req_last[id]});
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: a beat is consumed when out_vld and low_empty are both high.
  always @(negedge clock) begin
    logic [DSIZE+IDW:0] e;
    if (out_vld === 1'b1 && low_empty === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got beat data=%0h id=%0d, required no beat", out_data, out_id);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e[DSIZE+IDW:IDW+1]));
        chk("sb_id",   32'(out_id),   32'(e[IDW:1]));
        chk("sb_last", 32'(out_last), 32'(e[0]));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    cfg_mask  = 4'hF;
    req_vld   = 4'hF;
    req_last  = 4'hF;
    req_data  = '0;
    low_empty = 1'b1;
    @(posedge clock);
    #1;

    // Reset: requests present but nothing may be accepted.
    for (int c = 0; c < 3; c++) cyc(4'b0000, 0, 1, 0, 8'h00);
    rst     = 1'b0;
    req_vld = 4'h0;
    for (int c = 0; c < 2; c++) cyc(4'b0000, 0, 1, 0, 8'h00);

    // Fair rotation: 0,1,2,3,0 -> pointer ends at 1.
    for (int i = 0; i < NUM; i++) set_data(i, 8'hC0 + 8'(i));
    req_vld = 4'hF;
    cyc(4'b0001, 0);
    cyc(4'b0010, 0);
    cyc(4'b0100, 0);
    cyc(4'b1000, 0);
    cyc(4'b0001, 0);
    req_vld = 4'h0;
    cyc(4'b0000, 0, 1, 1, 8'hC0);
    cyc(4'b0000, 0, 1, 0, 8'h00);

    // Packet lock: req1 sends A1,A2,A3 while req2 waits.
    req_vld  = 4'b0110;
    req_last = 4'b1101;
    set_data(2, 8'hB2);
    set_data(1, 8'hA1);
    cyc(4'b0010, 0);
    set_data(1, 8'hA2);
    cyc(4'b0010, 1);
    set_data(1, 8'hA3);
    req_last = 4'hF;
    cyc(4'b0010, 1, 1, 1, 8'hA2);
    req_vld = 4'b0100;
    cyc(4'b0100, 0, 1, 1, 8'hA3);
    req_vld = 4'h0;
    cyc(4'b0000, 0, 1, 1, 8'hB2);

    // Backpressure: pointer is 3, req0 loads 55 then stalls.
    req_vld = 4'b0001;
    set_data(0, 8'h55);
    cyc(4'b0001, 0);
    low_empty = 1'b0;
    set_data(0, 8'h66);
    for (int c = 0; c < 4; c++) cyc(4'b0000, 0, 1, 1, 8'h55);
    low_empty = 1'b1;
    cyc(4'b0001, 0, 1, 1, 8'h55);
    req_vld = 4'h0;
    cyc(4'b0000, 0, 1, 1, 8'h66);
    cyc(4'b0000, 0, 1, 0, 8'h00);

    // Mask: only 1 and 3 eligible, pointer starts at 1.
    cfg_mask = 4'b1010;
    req_vld  = 4'hF;
    for (int i = 0; i < NUM; i++) set_data(i, 8'h30 + 8'(i));
    cyc(4'b0010, 0);
    cyc(4'b1000, 0);
    cyc(4'b0010, 0);
    cyc(4'b1000, 0);
    cyc(4'b0010, 0);
    // req3 starts a packet, then its mask bit is cleared mid-packet.
    req_last = 4'b0111;
    set_data(3, 8'hD1);
    cyc(4'b1000, 0);
    cfg_mask = 4'b0010;
    set_data(3, 8'hD2);
    cyc(4'b1000, 1);
    req_last = 4'hF;
    set_data(3, 8'hD3);
    cyc(4'b1000, 1);
    cyc(4'b0010, 0);
    req_vld = 4'h0;
    cyc(4'b0000, 0);
    cyc(4'b0000, 0, 1, 0, 8'h00);

    // Mid-packet reset: req2 locks (pointer 2), then reset is applied.
    cfg_mask = 4'hF;
    req_vld  = 4'b0100;
    req_last = 4'b1011;
    set_data(2, 8'hE1);
    cyc(4'b0100, 0);
    set_data(2, 8'hE2);
    cyc(4'b0100, 1);
    rst = 1'b1;
    cyc(4'b0000, 1, 1, 1, 8'hE2);
    rst      = 1'b0;
    req_vld  = 4'h0;
    req_last = 4'hF;
    cyc(4'b0000, 0, 1, 0, 8'h00);
    // Pointer back at 0: lowest eligible (1) wins over 3.
    req_vld = 4'b1010;
    set_data(1, 8'h71);
    set_data(3, 8'h73);
    cyc(4'b0010, 0);
    req_vld = 4'h0;
    cyc(4'b0000, 0, 1, 1, 8'h71);
    cyc(4'b0000, 0, 1, 0, 8'h00);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
